// File: rtl/mc_dp_pkg.sv
// mc_dp_pkg: shared state, opcode, extender and instruction-field definitions for the multicycle datapath.
package mc_dp_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      EXECUTE,
      ALUWB,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      BRANCH
   } state_t;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] IMM_8    = 2'b00;
   localparam logic [1:0] IMM_12   = 2'b01;
   localparam logic [1:0] IMM_24   = 2'b10;
   localparam logic [1:0] IMM_ZERO = 2'b11;

   localparam int FLD_W  = 4;
   localparam int RN_LSB = 16;
   localparam int RD_LSB = 12;
   localparam int RM_LSB = 0;

   function automatic logic [FLD_W-1:0] reg_field(input logic [31:0] i, input int lsb);
      return i[lsb +: FLD_W];
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: NREGS x WIDTH register file, two async reads, one sync write; the top index aliases PC+4.
module mc_regfile
   import mc_dp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREGS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [FLD_W-1:0] ra1,
   input  logic [FLD_W-1:0] ra2,
   input  logic             we,
   input  logic [FLD_W-1:0] wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [WIDTH-1:0] pc_alias,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2
);

   localparam logic [FLD_W-1:0] PC_IDX = FLD_W'(NREGS - 1);

   logic [WIDTH-1:0] rf [NREGS];

   // writes to the PC index are steered to the PC register by the top
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else if (we && wa != PC_IDX) begin
         rf[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == PC_IDX) ? pc_alias : rf[ra1];
   assign rd2 = (ra2 == PC_IDX) ? pc_alias : rf[ra2];

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle ARM-subset datapath with step sequencer and req/ready unified memory port.
// Define MC_DATAPATH_PERF_EN to add cycle_count/retire_count performance counters.
module mc_datapath
   import mc_dp_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int               NREGS    = 16
) (
   input  logic             clk,
   input  logic             reset,
   output logic [31:0]      instr,
   input  logic [1:0]       op_class,
   input  logic             is_load,
   input  logic             cond_pass,
   input  logic [1:0]       reg_src,
   input  logic [1:0]       imm_src,
   input  logic             alu_src,
   input  logic [1:0]       alu_control,
   input  logic             reg_write,
   input  logic             set_flags,
   output logic [3:0]       alu_flags,
   output logic [WIDTH-1:0] pc,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ready,
`ifdef MC_DATAPATH_PERF_EN
   output logic             instr_retire,
   output logic [WIDTH-1:0] cycle_count,
   output logic [WIDTH-1:0] retire_count
`else
   output logic             instr_retire
`endif
);

   localparam logic [FLD_W-1:0] PC_IDX = FLD_W'(NREGS - 1);

   state_t state, state_n;

   logic [31:0]      ir;
   logic [WIDTH-1:0] pc_q, a, wd, alu_out, data;
   logic [3:0]       flags, nzcv_q, nzcv;
   logic [WIDTH-1:0] ext, src_b, b_eff, alu_y, rd1, rd2, rf_wd;
   logic [WIDTH:0]   sum_c;
   logic [1:0]       op;
   logic             sub, arith, ovf, rf_we, rd_is_pc;
   logic             req_i, we_i, ret_i;
   logic [FLD_W-1:0] rn, rd, rm, ra1, ra2;

   assign rn       = reg_field(ir, RN_LSB);
   assign rd       = reg_field(ir, RD_LSB);
   assign rm       = reg_field(ir, RM_LSB);
   assign rd_is_pc = rd == PC_IDX;
   assign ra1      = reg_src[0] ? PC_IDX : rn;
   assign ra2      = reg_src[1] ? rd : rm;

   always_comb begin
      ext = imm_src == IMM_8  ? WIDTH'(ir[7:0]) :
            imm_src == IMM_12 ? WIDTH'(ir[11:0]) :
            imm_src == IMM_24 ? {{(WIDTH-26){ir[23]}}, ir[23:0], 2'b00} : '0;
   end

   // address calculation and branch target reuse the adder with ADD forced
   assign op    = state == EXECUTE ? alu_control : ALU_ADD;
   assign src_b = (alu_src || state != EXECUTE) ? ext : wd;
   assign sub   = op == ALU_SUB;
   assign arith = !op[1];
   assign b_eff = sub ? ~src_b : src_b;
   assign sum_c = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
   assign alu_y = op == ALU_AND ? (a & src_b) : op == ALU_ORR ? (a | src_b) : sum_c[WIDTH-1:0];
   assign ovf   = arith && (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
   assign nzcv  = {alu_y[WIDTH-1], alu_y == '0, arith && sum_c[WIDTH], ovf};

   assign rf_we = (state == ALUWB && reg_write) || state == MEMWB;
   assign rf_wd = state == MEMWB ? data : alu_out;

   mc_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
      .clk      (clk),
      .reset    (reset),
      .ra1      (ra1),
      .ra2      (ra2),
      .we       (rf_we),
      .wa       (rd),
      .wd       (rf_wd),
      .pc_alias (pc_q + WIDTH'(4)),
      .rd1      (rd1),
      .rd2      (rd2)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      req_i   = 1'b0;
      we_i    = 1'b0;
      ret_i   = 1'b0;
      case (state)
         FETCH: begin
            req_i = 1'b1;
            if (mem_ready) state_n = DECODE;
         end
         DECODE: begin
            if (!cond_pass || op_class == OP_ILL) begin
               ret_i   = 1'b1;
               state_n = FETCH;
            end else begin
               state_n = op_class == OP_DP ? EXECUTE : op_class == OP_MEM ? MEMADR : BRANCH;
            end
         end
         EXECUTE: state_n = ALUWB;
         MEMADR:  state_n = is_load ? MEMREAD : MEMWRITE;
         MEMREAD: begin
            req_i = 1'b1;
            if (mem_ready) state_n = MEMWB;
         end
         MEMWRITE: begin
            req_i = 1'b1;
            we_i  = 1'b1;
            if (mem_ready) begin
               ret_i   = 1'b1;
               state_n = FETCH;
            end
         end
         ALUWB, MEMWB, BRANCH: begin
            ret_i   = 1'b1;
            state_n = FETCH;
         end
         default: state_n = FETCH;
      endcase
   end

   // reset abandons any pending access immediately
   assign mem_req      = req_i && !reset;
   assign mem_we       = we_i && !reset;
   assign instr_retire = ret_i && !reset;
   assign mem_addr     = state == FETCH ? pc_q : alu_out;
   assign mem_wdata    = wd;
   assign instr        = ir;
   assign pc           = pc_q;
   assign alu_flags    = flags;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         ir      <= '0;
         a       <= '0;
         wd      <= '0;
         alu_out <= '0;
         data    <= '0;
         flags   <= '0;
         nzcv_q  <= '0;
      end else begin
         if (state == FETCH && mem_ready) begin
            ir   <= mem_rdata[31:0];
            pc_q <= pc_q + WIDTH'(4);
         end
         if (state == DECODE) begin
            a  <= rd1;
            wd <= rd2;
         end
         if (state == EXECUTE) begin
            alu_out <= alu_y;
            nzcv_q  <= nzcv;
         end
         if (state == MEMADR) alu_out <= alu_y;
         if (state == MEMREAD && mem_ready) data <= mem_rdata;
         if (state == ALUWB && set_flags) flags <= nzcv_q;
         if (((state == ALUWB && reg_write) || state == MEMWB) && rd_is_pc) pc_q <= rf_wd;
         if (state == BRANCH) pc_q <= alu_y;
      end
   end

`ifdef MC_DATAPATH_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_count  <= '0;
         retire_count <= '0;
      end else begin
         cycle_count <= cycle_count + WIDTH'(1);
         if (instr_retire) retire_count <= retire_count + WIDTH'(1);
      end
   end
`else
`endif

endmodule
